// File: rtl/commit_flush_ctrl.sv
// Turns the commit stage's single-cycle fence/flush pulses into the ordered
// drain -> D$ -> I$/TLB -> pipeline-redirect sequence, holding commit meanwhile.
//
// state     | meaning
// IDLE      | waiting for a retiring fence/flush request
// DRAIN     | waiting for the store buffer to empty
// DC_FLUSH  | D$ flush requested, waiting for ack or watchdog
// IC_FLUSH  | one-cycle I$ flush pulse
// TLB_FLUSH | one-cycle TLB flush pulse
// DONE      | pipeline flush and fetch redirect to pc + 4
module commit_flush_ctrl #(
  parameter int unsigned          TIMEOUT_W     = 16,
  parameter logic [TIMEOUT_W-1:0] FLUSH_TIMEOUT = 16'd4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fence_i_i,
  input  logic        fence_i,
  input  logic        sfence_vma_i,
  input  logic        flush_commit_i,
  input  logic [63:0] pc_commit_i,
  input  logic        no_st_pending_i,
  input  logic        dcache_flush_ack_i,
  output logic        halt_o,
  output logic        flush_dcache_o,
  output logic        flush_icache_o,
  output logic        flush_tlb_o,
  output logic        flush_pipeline_o,
  output logic        set_pc_o,
  output logic [63:0] pc_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, DC_FLUSH, IC_FLUSH, TLB_FLUSH, DONE
  } state_e;

  localparam int K_FENCE_I = 0;
  localparam int K_FENCE   = 1;
  localparam int K_SFENCE  = 2;
  localparam int K_COMMIT  = 3;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = FLUSH_TIMEOUT - TIMEOUT_W'(1);

  state_e               state_q, state_d;
  logic [3:0]           kind_q, kind_d;
  logic [63:0]          pc_q, pc_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic        halt_q, flush_dcache_q, flush_icache_q, flush_tlb_q;
  logic        flush_pipeline_q, set_pc_q;
  logic [63:0] pc_o_q;
  logic        cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fence_i_i) begin
          kind_d  = 4'b0001 << K_FENCE_I;
          pc_d    = pc_commit_i;
          state_d = DRAIN;
        end else if (fence_i) begin
          kind_d  = 4'b0001 << K_FENCE;
          pc_d    = pc_commit_i;
          state_d = DRAIN;
        end else if (sfence_vma_i) begin
          kind_d  = 4'b0001 << K_SFENCE;
          pc_d    = pc_commit_i;
          state_d = DRAIN;
        end else if (flush_commit_i) begin
          kind_d  = 4'b0001 << K_COMMIT;
          pc_d    = pc_commit_i;
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (no_st_pending_i) begin
          cnt_d = '0;
          if (kind_q[K_SFENCE])      state_d = TLB_FLUSH;
          else if (kind_q[K_COMMIT]) state_d = DONE;
          else                       state_d = DC_FLUSH;
        end
      end
      DC_FLUSH: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (dcache_flush_ack_i || cnt_last)
          state_d = kind_q[K_FENCE_I] ? IC_FLUSH : DONE;
      end
      IC_FLUSH:  state_d = DONE;
      TLB_FLUSH: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      kind_q           <= '0;
      pc_q             <= '0;
      cnt_q            <= '0;
      halt_q           <= 1'b0;
      flush_dcache_q   <= 1'b0;
      flush_icache_q   <= 1'b0;
      flush_tlb_q      <= 1'b0;
      flush_pipeline_q <= 1'b0;
      set_pc_q         <= 1'b0;
      pc_o_q           <= '0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      pc_q             <= pc_d;
      cnt_q            <= cnt_d;
      halt_q           <= (state_d != IDLE);
      flush_dcache_q   <= (state_d == DC_FLUSH);
      flush_icache_q   <= (state_d == IC_FLUSH);
      flush_tlb_q      <= (state_d == TLB_FLUSH);
      flush_pipeline_q <= (state_d == DONE);
      set_pc_q         <= (state_d == DONE);
      pc_o_q           <= (state_d == DONE) ? pc_d + 64'd4 : '0;
    end
  end

  assign halt_o           = halt_q;
  assign flush_dcache_o   = flush_dcache_q;
  assign flush_icache_o   = flush_icache_q;
  assign flush_tlb_o      = flush_tlb_q;
  assign flush_pipeline_o = flush_pipeline_q;
  assign set_pc_o         = set_pc_q;
  assign pc_o             = pc_o_q;
  // A late ack wins over the watchdog, so the pulse cannot be registered ahead of time.
  assign timeout_o        = (state_q == DC_FLUSH) && cnt_last && !dcache_flush_ack_i;

endmodule

// File: tb/tb_commit_flush_ctrl.sv
// Randomized bench for commit_flush_ctrl: each request is expanded into an
// expected per-cycle timeline from the sequencing rules and compared cycle by cycle.
module tb_commit_flush_ctrl;

  localparam int FT = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fence_i_i, fence_i, sfence_vma_i, flush_commit_i;
  logic [63:0] pc_commit_i;
  logic        no_st_pending_i, dcache_flush_ack_i;
  logic        halt_o, flush_dcache_o, flush_icache_o, flush_tlb_o;
  logic        flush_pipeline_o, set_pc_o, timeout_o;
  logic [63:0] pc_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  commit_flush_ctrl #(.TIMEOUT_W(16), .FLUSH_TIMEOUT(16'(FT))) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .fence_i_i          (fence_i_i),
    .fence_i            (fence_i),
    .sfence_vma_i       (sfence_vma_i),
    .flush_commit_i     (flush_commit_i),
    .pc_commit_i        (pc_commit_i),
    .no_st_pending_i    (no_st_pending_i),
    .dcache_flush_ack_i (dcache_flush_ack_i),
    .halt_o             (halt_o),
    .flush_dcache_o     (flush_dcache_o),
    .flush_icache_o     (flush_icache_o),
    .flush_tlb_o        (flush_tlb_o),
    .flush_pipeline_o   (flush_pipeline_o),
    .set_pc_o           (set_pc_o),
    .pc_o               (pc_o),
    .timeout_o          (timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {halt, dcache, icache, tlb, pipeline, set_pc, timeout}
  function automatic logic [63:0] ctrl_now();
    return {57'b0, halt_o, flush_dcache_o, flush_icache_o, flush_tlb_o,
            flush_pipeline_o, set_pc_o, timeout_o};
  endfunction

  task automatic idle_inputs();
    {flush_commit_i, sfence_vma_i, fence_i, fence_i_i} = 4'b0;
    pc_commit_i        = '0;
    no_st_pending_i    = 1'b1;
    dcache_flush_ack_i = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk_i); #1;
    idle_inputs();
    dcache_flush_ack_i = ($urandom_range(0, 3) == 0);
    #1;
    chk({tag, "_ctrl"}, ctrl_now(), 64'd0);
    chk({tag, "_pc"}, pc_o, 64'd0);
  endtask

  // req bits: [0] fence.i, [1] fence, [2] sfence.vma, [3] flush_commit
  task automatic run_txn(input string tag, input logic [3:0] req, input logic [63:0] pc,
                         input int nsp_low, input int ack_cyc, input bit noise);
    bit         nsp_a[32];
    bit         ack_a[32];
    logic [3:0] nreq[32];
    int         s, e, icc, tlc, done, d;
    logic [6:0] exp_ctrl;
    logic [63:0] exp_pc;
    for (int t = 0; t < 32; t++) begin
      nsp_a[t] = (t > nsp_low) ? 1'b1 : (noise ? ($urandom_range(0, 3) == 0) : 1'b0);
      ack_a[t] = (ack_cyc > 0 && t == ack_cyc) || (noise && $urandom_range(0, 7) == 0);
      nreq[t]  = (noise && $urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
    end
    s = -1; e = -1; icc = -1; tlc = -1;
    if (req[0] || req[1] || req[2]) begin
      d = 1;
      while (!nsp_a[d]) d++;
      if (!req[0] && !req[1]) begin
        tlc  = d + 1;
        done = d + 2;
      end else begin
        s = d + 1;
        e = s;
        while (!ack_a[e] && e != s + FT - 1) e++;
        if (req[0]) begin
          icc  = e + 1;
          done = e + 2;
        end else begin
          done = e + 1;
        end
      end
    end else begin
      done = 1;
    end
    for (int t = 0; t <= done; t++) begin
      @(posedge clk_i); #1;
      if (t == 0) begin
        {flush_commit_i, sfence_vma_i, fence_i, fence_i_i} = req;
        pc_commit_i = pc;
      end else begin
        {flush_commit_i, sfence_vma_i, fence_i, fence_i_i} = nreq[t];
        pc_commit_i = noise ? {$urandom, $urandom} : 64'd0;
      end
      no_st_pending_i    = nsp_a[t];
      dcache_flush_ack_i = ack_a[t];
      #1;
      exp_ctrl = {t >= 1 && t <= done, s >= 0 && t >= s && t <= e, t == icc, t == tlc,
                  t == done, t == done, s >= 0 && t == e && !ack_a[e]};
      exp_pc   = (t == done) ? pc + 64'd4 : 64'd0;
      chk($sformatf("%s_ctrl_c%0d", tag, t), ctrl_now(), {57'b0, exp_ctrl});
      chk($sformatf("%s_pc_c%0d", tag, t), pc_o, exp_pc);
    end
  endtask

  task automatic reset_mid_flush();
    logic [6:0] exp_seq[6];
    exp_seq[0] = 7'b0000000;
    exp_seq[1] = 7'b1000000;
    exp_seq[2] = 7'b1100000;
    exp_seq[3] = 7'b1100000;
    exp_seq[4] = 7'b1100000;
    exp_seq[5] = 7'b0000000;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk_i); #1;
      idle_inputs();
      if (t == 0) begin
        fence_i_i   = 1'b1;
        pc_commit_i = 64'h0000_0000_1234_5678;
      end
      rst_i = (t == 4);
      #1;
      chk($sformatf("rst_ctrl_c%0d", t), ctrl_now(), {57'b0, exp_seq[t]});
      chk($sformatf("rst_pc_c%0d", t), pc_o, 64'd0);
    end
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]  req;
    logic [63:0] pc;
    rst_i = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ctrl", ctrl_now(), 64'd0);
    chk("reset_pc", pc_o, 64'd0);
    rst_i = 1'b0;

    run_txn("fencei",  4'b0001, 64'h8000_0100, 0, 5, 1'b0);
    run_txn("sfence",  4'b0100, 64'h0000_0000_0040_0000, 3, 0, 1'b0);
    run_txn("commit",  4'b1000, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1'b0);
    run_txn("fence_to", 4'b0110, 64'h0000_0001_0000_0008, 0, 0, 1'b0);
    run_txn("fence_ackto", 4'b0010, 64'h0000_0000_0000_1000, 0, 9, 1'b0);
    idle_cycle("gap");
    reset_mid_flush();
    run_txn("post_rst", 4'b1000, 64'h0000_0000_0000_2000, 0, 0, 1'b0);
    run_txn("noisy_fencei", 4'b0001, 64'h8000_0200, 2, 6, 1'b1);

    for (int i = 0; i < 150; i++) begin
      req = 4'($urandom_range(1, 15));
      pc  = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                        : {$urandom, $urandom};
      run_txn($sformatf("rnd%0d", i), req, pc, $urandom_range(0, 4),
              $urandom_range(0, 16), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) idle_cycle($sformatf("rnd%0d_gap", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
